// File: rtl/riscv_defs_pkg.sv
// Shared definitions for the instruction fetch unit.
// Build option: RISCV_FETCH_SKID_EN selects a two-entry fetch buffer
// (one-entry buffer when undefined).
package riscv_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

`ifdef RISCV_FETCH_SKID_EN
  localparam int FETCH_BUF_DEPTH = 2;
`else
  localparam int FETCH_BUF_DEPTH = 1;
`endif

  localparam int FETCH_CNT_W = $clog2(FETCH_BUF_DEPTH + 1);

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_buf.sv
// Small shift-style FIFO: head always sits in slot 0, so the output is a
// plain register read. Push and pop may coincide; flush empties it at the edge.
module riscv_fetch_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [DEPTH:0][W-1:0]   ext;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           wr_idx;

  // A zero slot above the top entry lets the shift read i+1 without a range guard.
  assign ext    = {{W{1'b0}}, mem_q};
  assign wr_idx = count_q - CW'(pop);
  assign head   = mem_q[0];
  assign count  = count_q;

  // Next storage contents: shift down on pop, then write the new entry behind the survivors.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pop) mem_d[i] = ext[i+1];
      if (push && (CW'(i) == wr_idx)) mem_d[i] = din;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch front end: one outstanding I-cache request, redirect
// with in-flight response squashing, and a small buffer towards decode.
// Build option: RISCV_FETCH_SKID_EN (buffer depth 2 instead of 1).
module riscv_fetch
  import riscv_defs_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_branch_i,
  input  logic [31:0] fetch_branch_pc_i,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [31:0] icache_inst_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  input  logic        fetch_accept_i
);

  fetch_state_e           state_q;
  logic [31:0]            pc_q;
  logic [31:0]            req_pc_q;
  logic                   drop_q;

  logic [31:0]            branch_pc;
  logic                   outstanding;
  logic                   buf_push, buf_pop, buf_empty, room;
  logic [FETCH_CNT_W-1:0] buf_count;
  fetch_entry_t           buf_din, buf_head;

  assign branch_pc   = fetch_branch_pc_i & ~32'h3;
  // A request is in flight in WAIT, or after a redirect until its response is squashed.
  assign outstanding = (state_q == ST_WAIT) || drop_q;

  assign buf_empty     = (buf_count == '0);
  assign fetch_valid_o = !buf_empty && !fetch_branch_i;
  assign buf_pop       = fetch_valid_o && fetch_accept_i;
  assign room          = (buf_count - FETCH_CNT_W'(buf_pop)) < FETCH_CNT_W'(FETCH_BUF_DEPTH);

  // Holding off while a squashed response is pending keeps a single request in flight.
  assign icache_rd_o = (state_q == ST_REQ) && !fetch_branch_i && !drop_q && room;
  assign icache_pc_o = pc_q;

  assign buf_push = icache_valid_i && !fetch_branch_i && (state_q == ST_WAIT) && !drop_q;
  assign buf_din  = '{instr: icache_inst_i, pc: req_pc_q};

  // Empty buffer shows NOP once running; before the first redirect everything reads zero.
  assign fetch_instr_o = !buf_empty ? buf_head.instr :
                         (state_q == ST_IDLE) ? 32'h0 : NOP_INSTR;
  assign fetch_pc_o    = buf_empty ? 32'h0 : buf_head.pc;

  // Fetch sequencing: start/redirect, request handshake, response tracking and squash.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      pc_q     <= 32'h0;
      req_pc_q <= 32'h0;
      drop_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_branch_i) begin
            state_q <= ST_REQ;
            pc_q    <= branch_pc;
          end
        end
        ST_REQ, ST_WAIT: begin
          if (fetch_branch_i) begin
            state_q <= ST_REQ;
            pc_q    <= branch_pc;
            drop_q  <= outstanding && !icache_valid_i;
          end else begin
            if (state_q == ST_REQ && icache_rd_o && icache_accept_i) begin
              state_q  <= ST_WAIT;
              pc_q     <= pc_q + 32'd4;
              req_pc_q <= pc_q;
            end
            if (state_q == ST_WAIT && icache_valid_i) state_q <= ST_REQ;
            if (drop_q && icache_valid_i) drop_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  riscv_fetch_buf #(
    .DEPTH (FETCH_BUF_DEPTH),
    .W     ($bits(fetch_entry_t)),
    .CW    (FETCH_CNT_W)
  ) u_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (buf_push),
    .pop    (buf_pop),
    .flush  (fetch_branch_i),
    .din    (buf_din),
    .head   (buf_head),
    .count  (buf_count)
  );

endmodule

// File: doc/riscv_fetch.md
RISCV_FETCH -- requirements
Module: riscv_fetch

Interface
REQ-001 SHALL have no parameters; buffer depth is set only by the configuration macro in REQ-026.
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port fetch_branch_i, input, 1: redirect request from execute; also carries the post-reset start.
REQ-005 SHALL have port fetch_branch_pc_i, input, 32: redirect target; bits [1:0] are treated as zero.
REQ-006 SHALL have port icache_rd_o, output, 1: instruction read request.
REQ-007 SHALL have port icache_pc_o, output, 32: request address, word aligned.
REQ-008 SHALL have port icache_accept_i, input, 1: request taken this cycle.
REQ-009 SHALL have port icache_valid_i, input, 1: response valid.
REQ-010 SHALL have port icache_inst_i, input, 32: response instruction word.
REQ-011 SHALL have port fetch_valid_o, output, 1: instruction available to decode.
REQ-012 SHALL have port fetch_instr_o, output, 32: instruction word.
REQ-013 SHALL have port fetch_pc_o, output, 32: PC of fetch_instr_o.
REQ-014 SHALL have port fetch_accept_i, input, 1: decode consumes the head entry when it is high together with fetch_valid_o.

Function
REQ-015 SHALL implement states IDLE, REQ and WAIT.
- IDLE -> REQ on fetch_branch_i.
- REQ -> WAIT when icache_rd_o and icache_accept_i are both high.
- WAIT -> REQ on a response or on a branch.
REQ-016 SHALL keep at most one request outstanding.
REQ-017 SHALL assert icache_rd_o only when all hold: state is REQ, fetch_branch_i is low, and (buffer occupancy minus any pop this cycle) is less than depth.
REQ-018 SHALL drive icache_pc_o from pc_q, and hold pc_q and icache_rd_o stable until accepted.
REQ-019 SHALL load pc_q <= pc_q + 4 on accept (32-bit wrap: 0xFFFFFFFC -> 0x00000000) and latch the request PC into req_pc_q.
REQ-020 SHALL, on fetch_branch_i:
- load pc_q <= {fetch_branch_pc_i[31:2], 2'b00};
- flush the buffer at the edge;
- set state to REQ;
- set drop_q if a request is outstanding and its response has not arrived this cycle.
REQ-021 SHALL discard the first response while drop_q is set and clear drop_q at that response; any icache_valid_i arriving with fetch_branch_i high is also discarded.
REQ-022 SHALL push each non-discarded response as {icache_inst_i, req_pc_q} into a FIFO-ordered buffer.
REQ-023 SHALL support push and pop in the same cycle; occupancy never exceeds depth, which REQ-017 guarantees.
REQ-024 SHALL drive fetch_valid_o = (buffer non-empty) AND NOT fetch_branch_i, with fetch_instr_o and fetch_pc_o taken from the buffer head.
REQ-025 SHALL give a minimum latency of 1 cycle from icache_valid_i to fetch_valid_o (registered buffer).

Configuration
REQ-026 SHALL use macro RISCV_FETCH_SKID_EN:
- defined: buffer depth 2, allowing sustained one instruction per two cycles with decode back-pressure absorbed;
- undefined: depth 1, and requests issue only when the buffer is empty or popping this cycle.

Reset
REQ-027 SHALL, while rst_ni is low, asynchronously set:
- state IDLE;
- pc_q, req_pc_q = 0;
- drop_q = 0;
- buffer empty;
- icache_rd_o = 0, fetch_valid_o = 0, icache_pc_o = 0, fetch_instr_o = 0, fetch_pc_o = 0.
REQ-028 SHALL, on reset assertion mid-transaction, forget the outstanding request; a late response while in IDLE is ignored.

Structure
REQ-029 SHALL place in riscv_defs_pkg.sv:
- the state enum;
- the FETCH_BUF_DEPTH constant (2 or 1 per REQ-026);
- the NOP word 32'h00000013, used as the empty-buffer value of fetch_instr_o.
REQ-030 SHALL instantiate one sub-module, riscv_fetch_buf: a parameterised FIFO with push, pop, flush, and a count output.

Verification
REQ-031 SHALL cover: reset release with no branch -> icache_rd_o stays 0 for 10 cycles; then branch to 0x80000000 -> the next cycle requests PC 0x80000000.
REQ-032 SHALL cover: branch to 0x80000000, always-accept memory with 1-cycle response, fetch_accept_i=1 -> fetch_pc_o sequence 0x80000000, 0x80000004, 0x80000008.
REQ-033 SHALL cover: branch to 0x100 while a response for 0x200 is outstanding -> 0x200 is never presented, and the next fetch_pc_o is 0x100.
REQ-034 SHALL cover: fetch_accept_i=0 for 8 cycles -> with SKID_EN, 2 entries are held and icache_rd_o=0; without SKID_EN, 1 entry; after release, order is preserved.
REQ-035 SHALL cover: branch to 0x00000103 -> icache_pc_o=0x00000100.
REQ-036 SHALL cover: rst_ni pulsed low during WAIT -> all outputs are 0 asynchronously, and a response arriving afterwards is ignored.
